// File: rtl/id_stage_pipelined_pkg.sv
// Shared decode constants for the ID stage: field positions, opcodes, ALU commands,
// condition codes and the condition-check helper.
package id_stage_pipelined_pkg;

  localparam int INSTR_W    = 32;
  localparam int FIELD_W    = 4;
  localparam int COND_LSB   = 28;
  localparam int MODE_LSB   = 26;
  localparam int I_BIT      = 25;
  localparam int OPCODE_LSB = 21;
  localparam int S_BIT      = 20;
  localparam int RN_LSB     = 16;
  localparam int RD_LSB     = 12;
  localparam int RM_LSB     = 0;

  typedef enum logic [1:0] {
    MODE_ARITH  = 2'b00,
    MODE_MEM    = 2'b01,
    MODE_BRANCH = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_CMD_NOP = 4'b0000;
  localparam logic [3:0] EXE_CMD_MOV = 4'b0001;
  localparam logic [3:0] EXE_CMD_ADD = 4'b0010;
  localparam logic [3:0] EXE_CMD_ADC = 4'b0011;
  localparam logic [3:0] EXE_CMD_SUB = 4'b0100;
  localparam logic [3:0] EXE_CMD_SBC = 4'b0101;
  localparam logic [3:0] EXE_CMD_AND = 4'b0110;
  localparam logic [3:0] EXE_CMD_ORR = 4'b0111;
  localparam logic [3:0] EXE_CMD_EOR = 4'b1000;
  localparam logic [3:0] EXE_CMD_MVN = 4'b1001;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_r;
    logic       mem_w;
    logic       wb_en;
    logic       b;
    logic       s;
  } ctrl_t;

  // nzcv = {N, Z, C, V}; NV never executes
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, ok;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: ok = z;
      COND_NE: ok = ~z;
      COND_CS: ok = c;
      COND_CC: ok = ~c;
      COND_MI: ok = n;
      COND_PL: ok = ~n;
      COND_VS: ok = v;
      COND_VC: ok = ~v;
      COND_HI: ok = c & ~z;
      COND_LS: ok = ~c | z;
      COND_GE: ok = (n == v);
      COND_LT: ok = (n != v);
      COND_GT: ok = ~z & (n == v);
      COND_LE: ok = z | (n != v);
      COND_AL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/id_stage_pipelined_reg_file_bypass.sv
// Register file, 2 combinational read ports and 1 write port, with optional
// same-cycle write-through to the read ports.
module reg_file_bypass
  import id_stage_pipelined_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 16,
  parameter int WB_BYP  = 1,
  localparam int AW     = $clog2(REG_CNT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [AW-1:0]                waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [1:0][FIELD_W-1:0]      raddr,
  output logic [1:0][DATA_W-1:0]       rdata
);

  logic [DATA_W-1:0] regs [REG_CNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < REG_CNT; r++) regs[r] <= '0;
    end else if (we && int'(waddr) < REG_CNT) begin
      regs[waddr] <= wdata;
    end
  end

  // Read addresses come straight from 4-bit instruction fields, so they may exceed REG_CNT
  always_comb begin
    rdata = '0;
    for (int p = 0; p < 2; p++) begin
      if (int'(raddr[p]) < REG_CNT) begin
        if (WB_BYP != 0 && we && FIELD_W'(waddr) == raddr[p])
          rdata[p] = wdata;
        else
          rdata[p] = regs[AW'(raddr[p])];
      end
    end
  end

endmodule

// File: rtl/id_stage_pipelined.sv
// Decode stage with built-in ID/EXE register: field split, control decode,
// condition check, register read and RAW hazard detection.
module id_stage_pipelined
  import id_stage_pipelined_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 16,
  parameter int FWD_EN  = 0,
  parameter int WB_BYP  = 1,
  localparam int REG_AW = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              instr_vld,
  input  logic [31:0]       instr_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [3:0]        status_in,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              exe_wb_en,
  input  logic              exe_mem_r,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              mem_wb_en,
  input  logic [REG_AW-1:0] mem_dest,
  output logic              stall_out,
  output logic              q_vld,
  output logic [DATA_W-1:0] q_pc,
  output logic [DATA_W-1:0] q_val_rn,
  output logic [DATA_W-1:0] q_val_rm,
  output logic [3:0]        q_exe_cmd,
  output logic              q_mem_r,
  output logic              q_mem_w,
  output logic              q_wb_en,
  output logic              q_b,
  output logic              q_s,
  output logic              q_i,
  output logic [REG_AW-1:0] q_dest,
  output logic [REG_AW-1:0] q_src1,
  output logic [REG_AW-1:0] q_src2,
  output logic [11:0]       q_shift_op,
  output logic [23:0]       q_imm24
);

  logic [FIELD_W-1:0] cond, opcode, rn, rd, rm, src2;
  mode_e              mode;
  logic               i_bit, s_bit;
  ctrl_t              ctrl;
  logic               cond_ok, use_rn, two_src;
  logic               exe_match, mem_match, hz, bubble;

  logic [1:0][FIELD_W-1:0] rf_raddr;
  logic [1:0][DATA_W-1:0]  rf_rdata;

  assign cond   = instr_in[COND_LSB +: 4];
  assign mode   = mode_e'(instr_in[MODE_LSB +: 2]);
  assign i_bit  = instr_in[I_BIT];
  assign opcode = instr_in[OPCODE_LSB +: 4];
  assign s_bit  = instr_in[S_BIT];
  assign rn     = instr_in[RN_LSB +: 4];
  assign rd     = instr_in[RD_LSB +: 4];
  assign rm     = instr_in[RM_LSB +: 4];

  // In memory mode the S bit is the load/store selector, not a flag update
  always_comb begin
    ctrl = '0;
    case (mode)
      MODE_ARITH: begin
        ctrl.s     = s_bit;
        ctrl.wb_en = 1'b1;
        case (opcode)
          OP_MOV:  ctrl.exe_cmd = EXE_CMD_MOV;
          OP_MVN:  ctrl.exe_cmd = EXE_CMD_MVN;
          OP_ADD:  ctrl.exe_cmd = EXE_CMD_ADD;
          OP_ADC:  ctrl.exe_cmd = EXE_CMD_ADC;
          OP_SUB:  ctrl.exe_cmd = EXE_CMD_SUB;
          OP_SBC:  ctrl.exe_cmd = EXE_CMD_SBC;
          OP_AND:  ctrl.exe_cmd = EXE_CMD_AND;
          OP_ORR:  ctrl.exe_cmd = EXE_CMD_ORR;
          OP_EOR:  ctrl.exe_cmd = EXE_CMD_EOR;
          OP_CMP: begin
            ctrl.exe_cmd = EXE_CMD_SUB;
            ctrl.wb_en   = 1'b0;
          end
          OP_TST: begin
            ctrl.exe_cmd = EXE_CMD_AND;
            ctrl.wb_en   = 1'b0;
          end
          default: ctrl.wb_en = 1'b0;
        endcase
      end
      MODE_MEM: begin
        ctrl.exe_cmd = EXE_CMD_ADD;
        ctrl.mem_r   = s_bit;
        ctrl.wb_en   = s_bit;
        ctrl.mem_w   = ~s_bit;
      end
      MODE_BRANCH: ctrl.b = 1'b1;
      default: ;
    endcase
  end

  assign cond_ok = cond_check(cond, status_in);
  assign src2    = ctrl.mem_w ? rd : rm;
  assign two_src = ~i_bit | ctrl.mem_w;
  assign use_rn  = ~ctrl.b & (opcode != OP_MOV) & (opcode != OP_MVN);

  always_comb begin
    exe_match = (use_rn && rn == FIELD_W'(exe_dest)) || (two_src && src2 == FIELD_W'(exe_dest));
    mem_match = (use_rn && rn == FIELD_W'(mem_dest)) || (two_src && src2 == FIELD_W'(mem_dest));
    if (FWD_EN != 0)
      hz = instr_vld && exe_mem_r && exe_match;
    else
      hz = instr_vld && ((exe_wb_en && exe_match) || (mem_wb_en && mem_match));
  end

  assign stall_out = hz & ~flush;
  assign bubble    = flush | hz | ~instr_vld;

  assign rf_raddr[0] = rn;
  assign rf_raddr[1] = src2;

  reg_file_bypass #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT),
    .WB_BYP  (WB_BYP)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_en),
    .waddr (wb_dest),
    .wdata (wb_value),
    .raddr (rf_raddr),
    .rdata (rf_rdata)
  );

  // Next ID/EXE contents; a bubble clears the whole slot, not just the controls
  logic              d_vld, d_i;
  ctrl_t             d_ctrl, q_ctrl;
  logic [DATA_W-1:0] d_pc, d_rn, d_rm;
  logic [REG_AW-1:0] d_dest, d_src1, d_src2;
  logic [11:0]       d_shift;
  logic [23:0]       d_imm;

  always_comb begin
    d_vld   = 1'b0;
    d_i     = 1'b0;
    d_ctrl  = '0;
    d_pc    = '0;
    d_rn    = '0;
    d_rm    = '0;
    d_dest  = '0;
    d_src1  = '0;
    d_src2  = '0;
    d_shift = '0;
    d_imm   = '0;
    if (!bubble) begin
      d_vld   = 1'b1;
      d_i     = i_bit;
      d_ctrl  = cond_ok ? ctrl : '0;
      d_pc    = pc_in;
      d_rn    = rf_rdata[0];
      d_rm    = rf_rdata[1];
      d_dest  = REG_AW'(rd);
      d_src1  = REG_AW'(rn);
      d_src2  = REG_AW'(src2);
      d_shift = instr_in[11:0];
      d_imm   = instr_in[23:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_vld      <= 1'b0;
      q_i        <= 1'b0;
      q_ctrl     <= '0;
      q_pc       <= '0;
      q_val_rn   <= '0;
      q_val_rm   <= '0;
      q_dest     <= '0;
      q_src1     <= '0;
      q_src2     <= '0;
      q_shift_op <= '0;
      q_imm24    <= '0;
    end else begin
      q_vld      <= d_vld;
      q_i        <= d_i;
      q_ctrl     <= d_ctrl;
      q_pc       <= d_pc;
      q_val_rn   <= d_rn;
      q_val_rm   <= d_rm;
      q_dest     <= d_dest;
      q_src1     <= d_src1;
      q_src2     <= d_src2;
      q_shift_op <= d_shift;
      q_imm24    <= d_imm;
    end
  end

  assign q_exe_cmd = q_ctrl.exe_cmd;
  assign q_mem_r   = q_ctrl.mem_r;
  assign q_mem_w   = q_ctrl.mem_w;
  assign q_wb_en   = q_ctrl.wb_en;
  assign q_b       = q_ctrl.b;
  assign q_s       = q_ctrl.s;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Scoreboard bench: dut 0 is FWD_EN=0/WB_BYP=1, dut 1 is FWD_EN=1/WB_BYP=0.
module tb_id_stage_pipelined;
  localparam int DW = 32;
  localparam int AW = 4;

  localparam logic [31:0] ADD123 = 32'hE0821003; // ADD R1,R2,R3
  localparam logic [31:0] MOVEQ  = 32'h01A05003; // MOVEQ R5,R3
  localparam logic [31:0] STR    = 32'hE4823008; // STR R3,[R2,#8]
  localparam logic [31:0] LDR    = 32'hE5926004; // LDR R6,[R2,...] Rm=4
  localparam logic [31:0] BR     = 32'hEA000010; // B +0x10

  typedef struct packed {
    logic          flush, instr_vld;
    logic [31:0]   instr;
    logic [DW-1:0] pc;
    logic [3:0]    status;
    logic          wb_en;
    logic [AW-1:0] wb_dest;
    logic [DW-1:0] wb_value;
    logic          exe_wb_en, exe_mem_r;
    logic [AW-1:0] exe_dest;
    logic          mem_wb_en;
    logic [AW-1:0] mem_dest;
  } stim_t;

  typedef struct packed {
    logic [DW-1:0] pc, val_rn, val_rm;
    logic [3:0]    exe_cmd;
    logic          mem_r, mem_w, wb_en, b, s, i;
    logic [AW-1:0] dest, src1, src2;
    logic [11:0]   shift_op;
    logic [23:0]   imm24;
  } obs_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    sel = 0;
  stim_t st = '0;
  stim_t in_s [2];
  obs_t  obs_o [2];
  logic  vld_o [2];
  logic  stall_o [2];
  obs_t  exp_q [2][$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  assign in_s[0] = (sel == 0) ? st : '0;
  assign in_s[1] = (sel == 1) ? st : '0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] pc, rn, rm;
    logic [3:0]    cmd;
    logic          mr, mw, wb, b, s, i, v, stl;
    logic [AW-1:0] dst, s1, s2;
    logic [11:0]   sh;
    logic [23:0]   imm;

    id_stage_pipelined #(.DATA_W(DW), .REG_CNT(16), .FWD_EN(g), .WB_BYP(1 - g)) dut (
      .clk(clk), .rst(rst), .flush(in_s[g].flush), .instr_vld(in_s[g].instr_vld),
      .instr_in(in_s[g].instr), .pc_in(in_s[g].pc), .status_in(in_s[g].status),
      .wb_en(in_s[g].wb_en), .wb_dest(in_s[g].wb_dest), .wb_value(in_s[g].wb_value),
      .exe_wb_en(in_s[g].exe_wb_en), .exe_mem_r(in_s[g].exe_mem_r), .exe_dest(in_s[g].exe_dest),
      .mem_wb_en(in_s[g].mem_wb_en), .mem_dest(in_s[g].mem_dest),
      .stall_out(stl), .q_vld(v), .q_pc(pc), .q_val_rn(rn), .q_val_rm(rm), .q_exe_cmd(cmd),
      .q_mem_r(mr), .q_mem_w(mw), .q_wb_en(wb), .q_b(b), .q_s(s), .q_i(i),
      .q_dest(dst), .q_src1(s1), .q_src2(s2), .q_shift_op(sh), .q_imm24(imm)
    );

    assign obs_o[g]   = {pc, rn, rm, cmd, mr, mw, wb, b, s, i, dst, s1, s2, sh, imm};
    assign vld_o[g]   = v;
    assign stall_o[g] = stl;

    always @(negedge clk) begin : mon
      obs_t e;
      if (vld_o[g] === 1'b1) begin
        checks++;
        if (exp_q[g].size() == 0) begin
          errors++;
          $display("FAIL dut%0d unexpected issue: got %h required no output", g, obs_o[g]);
        end else begin
          e = exp_q[g].pop_front();
          if (obs_o[g] !== e) begin
            errors++;
            $display("FAIL dut%0d idexe pc=%h: got %h required %h", g, e.pc, obs_o[g], e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic obs_t ex(input logic [DW-1:0] pc, rn, rm, input logic [3:0] cmd,
                              input logic mr, mw, wb, b, s, input logic [31:0] ins,
                              input logic [AW-1:0] src2);
    obs_t o;
    o = '{pc: pc, val_rn: rn, val_rm: rm, exe_cmd: cmd, mem_r: mr, mem_w: mw, wb_en: wb,
          b: b, s: s, i: ins[25], dest: ins[15:12], src1: ins[19:16], src2: src2,
          shift_op: ins[11:0], imm24: ins[23:0]};
    return o;
  endfunction

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic tick_chk(input int d, input logic exp_stall, input string nm);
    @(negedge clk);
    chk($sformatf("%s stall dut%0d", nm, d), stall_o[d], exp_stall);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] v);
    st = '0;
    st.wb_en = 1'b1;
    st.wb_dest = a;
    st.wb_value = v;
    tick();
    st = '0;
  endtask

  task automatic set_ins(input logic [31:0] ins, input logic [DW-1:0] pc);
    st.instr_vld = 1'b1;
    st.instr = ins;
    st.pc = pc;
  endtask

  initial begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset q_vld dut%0d", d), vld_o[d], 1'b0);
      chk($sformatf("reset q_* dut%0d", d), obs_o[d], '0);
      chk($sformatf("reset stall dut%0d", d), stall_o[d], 1'b0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // ---- dut 0: non-forwarding, write-through ----
    sel = 0;
    wr(2, 5); wr(3, 7); wr(4, 32'h44);
    set_ins(ADD123, 'h100);
    exp_q[0].push_back(ex('h100, 5, 7, 4'b0010, 0, 0, 1, 0, 0, ADD123, 3));
    tick_chk(0, 0, "add");

    st.exe_wb_en = 1; st.exe_dest = 2; set_ins(ADD123, 'h104);
    tick_chk(0, 1, "exe_raw");
    st.exe_wb_en = 0;
    exp_q[0].push_back(ex('h104, 5, 7, 4'b0010, 0, 0, 1, 0, 0, ADD123, 3));
    tick_chk(0, 0, "exe_raw_clear");

    st.mem_wb_en = 1; st.mem_dest = 3; set_ins(ADD123, 'h108);
    tick_chk(0, 1, "mem_raw");
    st.mem_wb_en = 0;
    exp_q[0].push_back(ex('h108, 5, 7, 4'b0010, 0, 0, 1, 0, 0, ADD123, 3));
    tick_chk(0, 0, "mem_raw_clear");

    st.exe_wb_en = 1; st.exe_dest = 5; set_ins(ADD123, 'h10C);
    exp_q[0].push_back(ex('h10C, 5, 7, 4'b0010, 0, 0, 1, 0, 0, ADD123, 3));
    tick_chk(0, 0, "exe_nomatch");

    st.exe_dest = 0; st.status = 4'b0000; set_ins(MOVEQ, 'h110);
    exp_q[0].push_back(ex('h110, 0, 7, 4'b0000, 0, 0, 0, 0, 0, MOVEQ, 3));
    tick_chk(0, 0, "moveq_fail");
    st.exe_wb_en = 0; st.status = 4'b0100; set_ins(MOVEQ, 'h114);
    exp_q[0].push_back(ex('h114, 0, 7, 4'b0001, 0, 0, 1, 0, 0, MOVEQ, 3));
    tick_chk(0, 0, "moveq_pass");
    st.status = 4'b0000;

    st.wb_en = 1; st.wb_dest = 3; st.wb_value = 32'hDEADBEEF; set_ins(ADD123, 'h118);
    exp_q[0].push_back(ex('h118, 5, 32'hDEADBEEF, 4'b0010, 0, 0, 1, 0, 0, ADD123, 3));
    tick_chk(0, 0, "wb_bypass");
    st.wb_en = 0; set_ins(ADD123, 'h11C);
    exp_q[0].push_back(ex('h11C, 5, 32'hDEADBEEF, 4'b0010, 0, 0, 1, 0, 0, ADD123, 3));
    tick_chk(0, 0, "wb_written");

    st.flush = 1; st.exe_wb_en = 1; st.exe_dest = 2; set_ins(ADD123, 'h120);
    tick_chk(0, 0, "flush_hz");
    st.exe_wb_en = 0;
    tick_chk(0, 0, "flush_only");
    st.flush = 0;

    st.exe_wb_en = 1; st.exe_dest = 3; set_ins(STR, 'h124);
    tick_chk(0, 1, "str_rd_raw");
    st.exe_wb_en = 0;
    exp_q[0].push_back(ex('h124, 5, 32'hDEADBEEF, 4'b0010, 0, 1, 0, 0, 0, STR, 3));
    tick_chk(0, 0, "str");

    set_ins(LDR, 'h128);
    exp_q[0].push_back(ex('h128, 5, 32'h44, 4'b0010, 1, 0, 1, 0, 0, LDR, 4));
    tick_chk(0, 0, "ldr");

    st.exe_wb_en = 1; st.exe_dest = 0; set_ins(BR, 'h12C);
    exp_q[0].push_back(ex('h12C, 0, 0, 4'b0000, 0, 0, 0, 1, 0, BR, 0));
    tick_chk(0, 0, "branch");
    st = '0;
    tick_chk(0, 0, "idle");

    // ---- dut 1: forwarding, no write-through ----
    sel = 1;
    wr(2, 5); wr(3, 7);
    st.exe_wb_en = 1; st.exe_dest = 2; set_ins(ADD123, 'h200);
    exp_q[1].push_back(ex('h200, 5, 7, 4'b0010, 0, 0, 1, 0, 0, ADD123, 3));
    tick_chk(1, 0, "fwd_alu");
    st.exe_mem_r = 1; set_ins(ADD123, 'h204);
    tick_chk(1, 1, "load_use");
    st.exe_mem_r = 0; st.exe_wb_en = 0;
    exp_q[1].push_back(ex('h204, 5, 7, 4'b0010, 0, 0, 1, 0, 0, ADD123, 3));
    tick_chk(1, 0, "load_use_end");
    st.mem_wb_en = 1; st.mem_dest = 2; set_ins(ADD123, 'h208);
    exp_q[1].push_back(ex('h208, 5, 7, 4'b0010, 0, 0, 1, 0, 0, ADD123, 3));
    tick_chk(1, 0, "fwd_mem");
    st.mem_wb_en = 0;
    st.wb_en = 1; st.wb_dest = 3; st.wb_value = 32'hDEADBEEF; set_ins(ADD123, 'h20C);
    exp_q[1].push_back(ex('h20C, 5, 7, 4'b0010, 0, 0, 1, 0, 0, ADD123, 3));
    tick_chk(1, 0, "no_bypass");
    st.wb_en = 0; set_ins(ADD123, 'h210);
    exp_q[1].push_back(ex('h210, 5, 32'hDEADBEEF, 4'b0010, 0, 0, 1, 0, 0, ADD123, 3));
    tick_chk(1, 0, "no_bypass_written");
    st = '0;
    tick();

    // ---- reset mid-stream: live slot, pending stall and a write all discarded ----
    sel = 0;
    set_ins(ADD123, 'h300);
    tick();
    st = '0;
    set_ins(ADD123, 'h304);
    st.exe_wb_en = 1; st.exe_dest = 2;
    st.wb_en = 1; st.wb_dest = 7; st.wb_value = 32'h77;
    #1 rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midrst q_vld dut%0d", d), vld_o[d], 1'b0);
      chk($sformatf("midrst q_* dut%0d", d), obs_o[d], '0);
    end
    chk("midrst stall follows inputs dut0", stall_o[0], 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    st = '0;
    for (int d = 0; d < 2; d++) begin
      sel = d;
      for (int k = 0; k < 8; k++) begin
        logic [31:0] ins;
        ins = 32'hE0801000 | (32'(2 * k) << 16) | 32'(2 * k + 1);
        set_ins(ins, 32'(32'h400 + 4 * k));
        exp_q[d].push_back(ex(32'(32'h400 + 4 * k), 0, 0, 4'b0010, 0, 0, 1, 0, 0, ins, AW'(2 * k + 1)));
        tick_chk(d, 0, "post_rst_read");
      end
      st = '0;
    end

    tick(); tick();
    chk("dut0 scoreboard drained", exp_q[0].size(), 0);
    chk("dut1 scoreboard drained", exp_q[1].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
